// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants and enums for the fetch PC stage.
package fetch_pc_unit_pkg;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [5:0]  HALT_OPCODE = 6'h3F;
  localparam logic [31:0] BOOT_ADDR   = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {RUN, SQUASH, HALT} fetch_state_e;

  typedef enum logic [1:0] {SEQ, BR, J, JR} next_pc_sel_e;

  // Signed word offset to a byte displacement.
  function automatic logic [31:0] word_offset_bytes(input logic [15:0] offset);
    return {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch stage bus: redirect/stall controls from decode, memory opcode, fetch status back.
interface fetch_pc_unit_if;

  logic        i_Stall;
  logic [5:0]  i_Instr_Ctr;
  logic        i_Branch_Taken;
  logic [15:0] i_Branch_Offset;
  logic        i_Jump;
  logic [25:0] i_Jump_Index;
  logic        i_Jump_Reg;
  logic [31:0] i_Reg_Target;
  logic [31:0] o_Addr;
  logic [31:0] o_Fetch_PC;
  logic [31:0] o_PC_Plus4;
  logic        o_Fetch_Valid;
  logic        o_Halted;
  logic [31:0] o_Instr_Count;

  modport master (
    input  i_Stall, i_Instr_Ctr, i_Branch_Taken, i_Branch_Offset,
    input  i_Jump, i_Jump_Index, i_Jump_Reg, i_Reg_Target,
    output o_Addr, o_Fetch_PC, o_PC_Plus4, o_Fetch_Valid, o_Halted, o_Instr_Count
  );

  modport slave (
    output i_Stall, i_Instr_Ctr, i_Branch_Taken, i_Branch_Offset,
    output i_Jump, i_Jump_Index, i_Jump_Reg, i_Reg_Target,
    input  o_Addr, o_Fetch_PC, o_PC_Plus4, o_Fetch_Valid, o_Halted, o_Instr_Count
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Redirect target computation and JR > J > branch priority select.
module fetch_next_pc
  import fetch_pc_unit_pkg::*;
(
  input  logic [31:0]  i_PC,
  input  logic [31:0]  i_PC_Plus4,
  input  logic         i_Branch_Taken,
  input  logic [15:0]  i_Branch_Offset,
  input  logic         i_Jump,
  input  logic [25:0]  i_Jump_Index,
  input  logic         i_Jump_Reg,
  input  logic [31:0]  i_Reg_Target,
  output next_pc_sel_e o_Sel,
  output logic [31:0]  o_Next_PC
);

  always_comb begin
    o_Sel     = SEQ;
    o_Next_PC = i_PC + 32'd4;
    if (i_Jump_Reg) begin
      o_Sel     = JR;
      o_Next_PC = i_Reg_Target & 32'hFFFF_FFFC;
    end else if (i_Jump) begin
      o_Sel     = J;
      o_Next_PC = {i_PC_Plus4[31:28], i_Jump_Index, 2'b00};
    end else if (i_Branch_Taken) begin
      o_Sel     = BR;
      o_Next_PC = i_PC_Plus4 + word_offset_bytes(i_Branch_Offset);
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencing ahead of a 1-cycle instruction memory.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
(
  input  logic i_Clk,
  input  logic i_Rst,
  fetch_pc_unit_if.master bus
);

  logic [31:0]  r_PC, r_Fetch_Addr, r_Count;
  logic         r_Valid;
  fetch_state_e r_State;

  logic [31:0]  pc_d, fetch_addr_d, count_d;
  logic         valid_d;
  fetch_state_e state_d;

  logic         fire;
  logic [31:0]  fetch_plus4;
  logic [31:0]  next_pc;
  next_pc_sel_e next_sel;

  assign fetch_plus4 = r_Fetch_Addr + 32'd4;
  assign fire        = r_Valid & ~bus.i_Stall & (r_State == RUN);

  fetch_next_pc u_next_pc (
    .i_PC            (r_PC),
    .i_PC_Plus4      (fetch_plus4),
    .i_Branch_Taken  (bus.i_Branch_Taken),
    .i_Branch_Offset (bus.i_Branch_Offset),
    .i_Jump          (bus.i_Jump),
    .i_Jump_Index    (bus.i_Jump_Index),
    .i_Jump_Reg      (bus.i_Jump_Reg),
    .i_Reg_Target    (bus.i_Reg_Target),
    .o_Sel           (next_sel),
    .o_Next_PC       (next_pc)
  );

  always_comb begin
    state_d      = r_State;
    pc_d         = r_PC;
    fetch_addr_d = r_Fetch_Addr;
    valid_d      = r_Valid;
    count_d      = (fire && (r_Count != 32'hFFFF_FFFF)) ? r_Count + 32'd1 : r_Count;
    unique case (r_State)
      RUN: begin
        if (!bus.i_Stall) begin
          if (fire && (bus.i_Instr_Ctr == HALT_OPCODE)) begin
            state_d = HALT;
            valid_d = 1'b0;
          end else if (fire && (next_sel != SEQ)) begin
            // The word already in flight at r_PC is fetched but discarded.
            pc_d         = next_pc;
            fetch_addr_d = r_PC;
            valid_d      = 1'b0;
            state_d      = SQUASH;
          end else begin
            pc_d         = r_PC + 32'd4;
            fetch_addr_d = r_PC;
            valid_d      = 1'b1;
          end
        end
      end
      SQUASH: begin
        if (!bus.i_Stall) begin
          pc_d         = r_PC + 32'd4;
          fetch_addr_d = r_PC;
          valid_d      = 1'b1;
          state_d      = RUN;
        end
      end
      HALT: valid_d = 1'b0;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_PC         <= RESET_PC;
      r_Fetch_Addr <= BOOT_ADDR;
      r_Valid      <= 1'b0;
      r_State      <= RUN;
      r_Count      <= 32'd0;
    end else begin
      r_PC         <= pc_d;
      r_Fetch_Addr <= fetch_addr_d;
      r_Valid      <= valid_d;
      r_State      <= state_d;
      r_Count      <= count_d;
    end
  end

  // Re-issuing r_Fetch_Addr keeps the memory output stable while stalled or halted.
  assign bus.o_Addr        = i_Rst ? BOOT_ADDR :
                             ((bus.i_Stall || (r_State == HALT)) ? r_Fetch_Addr : r_PC);
  assign bus.o_Fetch_PC    = r_Fetch_Addr;
  assign bus.o_PC_Plus4    = fetch_plus4;
  assign bus.o_Fetch_Valid = r_Valid;
  assign bus.o_Halted      = (r_State == HALT);
  assign bus.o_Instr_Count = r_Count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed and random checks of fetch_pc_unit against a decode-view reference model.
module tb_fetch_pc_unit;
  import fetch_pc_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [5:0]  mem_q;
  logic [31:0] halt_at;
  int n_tests = 0;
  int n_fail  = 0;

  // Model: what decode sees (presented PC/valid) and what is issued next.
  logic [31:0] m_cur, m_next, m_count;
  logic        m_valid, m_halted, m_bubble;

  fetch_pc_unit_if bus ();

  fetch_pc_unit dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] opcode_of(input logic [31:0] a);
    if (a == BOOT_ADDR || a == halt_at) return 6'h3F;
    if (a[7:2] == 6'h3F) return 6'h01;
    return a[7:2];
  endfunction

  always @(posedge clk) mem_q <= opcode_of(bus.o_Addr);
  assign bus.i_Instr_Ctr = mem_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = BOOT_ADDR; m_next = RESET_PC; m_count = 0;
    m_valid = 1'b0; m_halted = 1'b0; m_bubble = 1'b0;
  endtask

  task automatic model_advance();
    m_cur   = m_next;
    m_next  = m_next + 32'd4;
    m_valid = 1'b1;
  endtask

  task automatic step(input logic r, input logic s, input logic br, input logic [15:0] off,
                      input logic j, input logic [25:0] idx, input logic jr,
                      input logic [31:0] tgt);
    logic [31:0] exp_addr, t, p4, soff;
    @(negedge clk);
    rst = r; bus.i_Stall = s; bus.i_Branch_Taken = br; bus.i_Branch_Offset = off;
    bus.i_Jump = j; bus.i_Jump_Index = idx; bus.i_Jump_Reg = jr; bus.i_Reg_Target = tgt;
    #1;
    exp_addr = r ? BOOT_ADDR : ((s || m_halted) ? m_cur : m_next);
    check_eq("addr", bus.o_Addr, exp_addr);
    check_eq("fetch_pc", bus.o_Fetch_PC, m_cur);
    check_eq("pc_plus4", bus.o_PC_Plus4, m_cur + 32'd4);
    check_eq("valid", {31'd0, bus.o_Fetch_Valid}, {31'd0, m_valid});
    check_eq("halted", {31'd0, bus.o_Halted}, {31'd0, m_halted});
    check_eq("count", bus.o_Instr_Count, m_count);
    if (r) begin
      model_reset();
    end else if (!m_halted && !s) begin
      if (m_bubble) begin
        model_advance();
        m_bubble = 1'b0;
      end else if (m_valid) begin
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
        p4 = m_cur + 32'd4;
        soff = {{16{off[15]}}, off};
        if (opcode_of(m_cur) == HALT_OPCODE) begin
          m_halted = 1'b1;
          m_valid  = 1'b0;
        end else if (jr || j || br) begin
          if (jr)     t = {tgt[31:2], 2'b00};
          else if (j) t = {p4[31:28], idx, 2'b00};
          else        t = p4 + soff * 32'd4;
          m_cur    = m_next;
          m_next   = t;
          m_valid  = 1'b0;
          m_bubble = 1'b1;
        end else begin
          model_advance();
        end
      end else begin
        model_advance();
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; bus.i_Stall = 1'b0; bus.i_Branch_Taken = 1'b0; bus.i_Branch_Offset = 16'd0;
    bus.i_Jump = 1'b0; bus.i_Jump_Index = 26'd0; bus.i_Jump_Reg = 1'b0; bus.i_Reg_Target = 32'd0;
    halt_at = 32'h0000_0030;
    repeat (2) @(posedge clk);
    model_reset();
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);

    // Reset release: cycles 0..3.
    idle();
    check_eq("rel0_addr", bus.o_Addr, 32'h0);
    check_eq("rel0_valid", {31'd0, bus.o_Fetch_Valid}, 32'd0);
    idle();
    check_eq("rel1_pc", bus.o_Fetch_PC, 32'h0);
    check_eq("rel1_valid", {31'd0, bus.o_Fetch_Valid}, 32'd1);
    check_eq("rel1_addr", bus.o_Addr, 32'h4);
    idle();
    idle();
    check_eq("rel3_pc", bus.o_Fetch_PC, 32'h8);
    check_eq("rel3_count", bus.o_Instr_Count, 32'd2);
    idle();

    // Backward branch at 0x10.
    step(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 26'd0, 1'b0, 32'd0);
    check_eq("br_at_pc", bus.o_Fetch_PC, 32'h10);
    idle();
    check_eq("br_bubble", {31'd0, bus.o_Fetch_Valid}, 32'd0);

    // All three redirects together at 0x0C: JR wins.
    step(1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 26'h123, 1'b1, 32'h43);
    check_eq("br_tgt_pc", bus.o_Fetch_PC, 32'h0C);
    check_eq("br_tgt_valid", {31'd0, bus.o_Fetch_Valid}, 32'd1);
    idle();
    check_eq("jr_bubble", {31'd0, bus.o_Fetch_Valid}, 32'd0);

    // JR to 0x20, then stall it for three cycles.
    step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b1, 32'h20);
    check_eq("jr_tgt_pc", bus.o_Fetch_PC, 32'h40);
    idle();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 26'd0, 1'b0, 32'd0);
      check_eq("stall_pc", bus.o_Fetch_PC, 32'h20);
      check_eq("stall_addr", bus.o_Addr, 32'h20);
      check_eq("stall_count", bus.o_Instr_Count, 32'd7);
    end
    idle();
    idle();
    check_eq("unstall_pc", bus.o_Fetch_PC, 32'h24);
    idle();
    idle();

    // Halt opcode at 0x30 with a simultaneous branch.
    step(1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 26'd0, 1'b0, 32'd0);
    check_eq("halt_pc", bus.o_Fetch_PC, 32'h30);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, i[0], 1'b1, 16'h0004, 1'b1, 26'h55, 1'b0, 32'h80);
      check_eq("halt_flag", {31'd0, bus.o_Halted}, 32'd1);
      check_eq("halt_addr", bus.o_Addr, 32'h30);
      check_eq("halt_valid", {31'd0, bus.o_Fetch_Valid}, 32'd0);
    end

    // Reset from HALT.
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    idle();
    check_eq("rst_halt_halted", {31'd0, bus.o_Halted}, 32'd0);
    check_eq("rst_halt_count", bus.o_Instr_Count, 32'd0);
    check_eq("rst_halt_valid", {31'd0, bus.o_Fetch_Valid}, 32'd0);
    check_eq("rst_halt_addr", bus.o_Addr, 32'h0);

    // Reset from SQUASH.
    step(1'b0, 1'b0, 1'b1, 16'h0008, 1'b0, 26'd0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    idle();
    check_eq("rst_sq_halted", {31'd0, bus.o_Halted}, 32'd0);
    check_eq("rst_sq_count", bus.o_Instr_Count, 32'd0);
    check_eq("rst_sq_valid", {31'd0, bus.o_Fetch_Valid}, 32'd0);
    check_eq("rst_sq_addr", bus.o_Addr, 32'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r;
      r = ($urandom_range(0, 99) == 0);
      if (r) halt_at = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), 16'($urandom),
           ($urandom_range(0, 11) == 0), 26'($urandom & 32'hFF),
           ($urandom_range(0, 11) == 0), $urandom & 32'h0000_03FF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and fetch-sequencing stage directly upstream of the instruction memory.
- Drives the memory's word-aligned byte address; the memory registers its read on i_Clk.
- Consumes the returned opcode field to detect the halt instruction (opcode 6'h3F).
- Applies branch, jump and jump-register redirects, stalls and halt, and tells decode whether the instruction on the memory bus is valid.

Parameters:
- RESET_PC, 32'h0000_0000, first address issued after reset.
- HALT_OPCODE, 6'h3F, opcode that stops fetch.
- BOOT_ADDR, 32'hFFFF_FFFC, address driven during reset (memory returns the halt pattern for it).

Ports:
- i_Clk  input  1  clock, rising edge.
- i_Rst  input  1  synchronous, active-high reset.
- i_Stall  input  1  decode cannot accept; hold the current instruction.
- i_Instr_Ctr  input  6  opcode of the instruction currently on the memory output.
- i_Branch_Taken  input  1  redirect to the PC-relative target.
- i_Branch_Offset  input  16  signed word offset.
- i_Jump  input  1  redirect to the absolute jump target.
- i_Jump_Index  input  26  jump target index.
- i_Jump_Reg  input  1  redirect to i_Reg_Target.
- i_Reg_Target  input  32  register jump target; bits [1:0] ignored.
- o_Addr  output  32  address to instruction memory.
- o_Fetch_PC  output  32  address of the instruction currently presented.
- o_PC_Plus4  output  32  o_Fetch_PC + 4, used as the link value.
- o_Fetch_Valid  output  1  presented instruction is real and not squashed.
- o_Halted  output  1  halt reached; sticky until reset.
- o_Instr_Count  output  32  instructions accepted by decode.

Behaviour:
- Reset is synchronous, active-high, on i_Rst; clock is i_Clk.
- State registers: r_PC, r_Fetch_Addr, r_Valid, r_State, r_Count.
- States: RUN, SQUASH, HALT.
- Reset values: r_PC=RESET_PC, r_Fetch_Addr=BOOT_ADDR, r_Valid=0, r_State=RUN, r_Count=0, o_Halted=0.
- While i_Rst=1: o_Addr=BOOT_ADDR.
- Memory latency is 1 cycle: the address sampled at edge k is presented after edge k.
- Address mux: o_Addr = r_Fetch_Addr when i_Stall=1, or in HALT; otherwise r_PC. Re-reading the same word keeps the memory output stable.
- fire = r_Valid & ~i_Stall & (r_State==RUN).
- Halt: fire & i_Instr_Ctr==HALT_OPCODE -> HALT.
  - Halt has top priority; simultaneous redirects are ignored.
  - In HALT: r_Valid=0, r_PC frozen, o_Halted=1, all inputs except i_Rst ignored.
- Redirect priority: i_Jump_Reg > i_Jump > i_Branch_Taken, sampled only when fire=1.
  - Jump-register target: {i_Reg_Target[31:2],2'b00}.
  - Jump target: {o_PC_Plus4[31:28], i_Jump_Index, 2'b00}.
  - Branch target: o_PC_Plus4 + (sext32(i_Branch_Offset)<<2), mod 2^32.
  - On redirect: r_PC<=target, r_Fetch_Addr<=r_PC, r_Valid<=0, state->SQUASH.
  - The sequential word already being fetched is discarded. There is no delay slot; the bubble is one cycle.
- SQUASH: for exactly one cycle r_PC<=r_PC+4, r_Fetch_Addr<=r_PC, r_Valid<=1, then RUN.
  - Redirect and halt inputs are ignored in SQUASH.
  - i_Stall in SQUASH holds the state.
- RUN, no stall: r_PC<=r_PC+4 (wraps at 2^32), r_Fetch_Addr<=r_PC, r_Valid<=1.
- Stall: r_PC, r_Fetch_Addr and r_Valid hold. A redirect or halt asserted together with i_Stall is ignored; decode keeps it asserted until the stall clears.
- o_Instr_Count increments on each fire cycle and saturates at 32'hFFFF_FFFF.
- Reset mid-operation, including from HALT, returns all registers to their reset values at the next edge.

Decomposition:
- Shared package holds:
  - HALT_OPCODE, BOOT_ADDR, RESET_PC;
  - the state enum (RUN/SQUASH/HALT);
  - a next-PC select enum (SEQ/BR/J/JR).
- One natural sub-module, fetch_next_pc: purely combinational target computation and priority mux.
- The state machine and counters stay in fetch_pc_unit.

Test Plan:
- Reset release, memory words 0..3 are non-halt:
  - cycle 0: o_Addr=0, o_Fetch_Valid=0;
  - cycle 1: o_Fetch_PC=0, valid=1, o_Addr=4;
  - cycle 3: o_Fetch_PC=8, o_Instr_Count=2.
- Branch_Taken with offset 16'hFFFE at fetch PC 0x10:
  - next cycle valid=0;
  - following cycle o_Fetch_PC=0x0C, valid=1.
- i_Jump_Reg=1, i_Jump=1, Branch_Taken=1 together, Reg_Target=0x43:
  - JR wins; next presented PC=0x40 after a one-cycle bubble.
- i_Stall held 3 cycles at fetch PC 0x20:
  - o_Fetch_PC stays 0x20, o_Addr=0x20, count unchanged;
  - on release, PC 0x24 follows next cycle.
- Opcode 6'h3F presented valid at PC 0x30 with Branch_Taken=1:
  - o_Halted=1 next cycle; o_Addr fixed at 0x30; valid=0 thereafter.
- i_Rst during HALT and during SQUASH:
  - next cycle o_Halted=0, count=0, valid=0, o_Addr=0 after release.
